clock_set_ctrl: RTL and testbench

- Run/set sequencer for the BCD hh:mm:ss time counter.
- In run mode, generates the 1 Hz count-enable from the system clock.
- In set mode, pauses the counter and lets the user step hours and minutes with two pre-debounced buttons.
- On exit from set mode, commits the edited time with a one-cycle parallel load (seconds forced to 00).

---
 rtl/clock_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for a BCD hh:mm:ss counter: 1 Hz prescaler, hour/minute editing, commit load.
// Optional alarm editing and match flag when CLOCK_SET_ALARM_EN is defined.
module clock_set_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_MAX = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic       cnt_en,
  output logic       ld,
  output logic [3:0] ld_h1,
  output logic [3:0] ld_h0,
  output logic [3:0] ld_m1,
  output logic [3:0] ld_m0,
  output logic [1:0] sel
`ifdef CLOCK_SET_ALARM_EN
  ,
  output logic       alarm,
  output logic       alarm_sel
`endif
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    COMMIT = 3'd3
`ifdef CLOCK_SET_ALARM_EN
    ,
    SET_AH = 3'd4,
    SET_AM = 3'd5
`endif
  } state_t;

  // Two-digit BCD increment; out-of-range or non-BCD values restart at 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int maxv);
    logic [3:0] t, u;
    int         n;
    t = v[7:4];
    u = v[3:0];
    n = int'(t) * 10 + int'(u);
    if (t > 4'd9 || u > 4'd9 || n >= maxv) bcd_inc = 8'h00;
    else if (u == 4'd9)                    bcd_inc = {t + 4'd1, 4'd0};
    else                                   bcd_inc = {t, u + 4'd1};
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_prev_q, inc_prev_q;
  logic [7:0]    ldh_q, ldh_d, ldm_q, ldm_d;
  logic          mode_p, inc_p, leave_run;
`ifdef CLOCK_SET_ALARM_EN
  logic [7:0]    alh_q, alh_d, alm_q, alm_d;
  logic          alarm_q, alarm_d;
`endif

  assign mode_p = btn_mode & ~mode_prev_q;
  assign inc_p  = btn_inc  & ~inc_prev_q;

  // While the alarm is ringing, a mode press only silences it.
`ifdef CLOCK_SET_ALARM_EN
  assign leave_run = mode_p & ~alarm_q;
`else
  assign leave_run = mode_p;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ldh_d   = ldh_q;
    ldm_d   = ldm_q;
    cnt_en  = 1'b0;
    ld      = 1'b0;
    sel     = 2'd0;
`ifdef CLOCK_SET_ALARM_EN
    alh_d     = alh_q;
    alm_d     = alm_q;
    alarm_d   = alarm_q;
    alarm_sel = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (leave_run) begin
          state_d = SET_H;
          ldh_d   = {cur_h1, cur_h0};
          ldm_d   = {cur_m1, cur_m0};
        end else begin
          cnt_en  = (presc_q == PMAX);
          presc_d = cnt_en ? '0 : presc_q + PW'(1);
        end
`ifdef CLOCK_SET_ALARM_EN
        if (cnt_en && {cur_h1, cur_h0} == alh_q && {cur_m1, cur_m0} == alm_q) alarm_d = 1'b1;
        if (mode_p) alarm_d = 1'b0;
`endif
      end
      SET_H: begin
        sel = 2'd1;
        if (mode_p)     state_d = SET_M;
        else if (inc_p) ldh_d   = bcd_inc(ldh_q, HOUR_MAX);
      end
      SET_M: begin
        sel = 2'd2;
`ifdef CLOCK_SET_ALARM_EN
        if (mode_p)     state_d = SET_AH;
`else
        if (mode_p)     state_d = COMMIT;
`endif
        else if (inc_p) ldm_d   = bcd_inc(ldm_q, 59);
      end
`ifdef CLOCK_SET_ALARM_EN
      SET_AH: begin
        sel = 2'd3;
        if (mode_p)     state_d = SET_AM;
        else if (inc_p) alh_d   = bcd_inc(alh_q, HOUR_MAX);
      end
      SET_AM: begin
        sel       = 2'd3;
        alarm_sel = 1'b1;
        if (mode_p)     state_d = COMMIT;
        else if (inc_p) alm_d   = bcd_inc(alm_q, 59);
      end
`endif
      COMMIT: begin
        ld      = 1'b1;
        presc_d = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      presc_q     <= '0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      ldh_q       <= 8'h00;
      ldm_q       <= 8'h00;
`ifdef CLOCK_SET_ALARM_EN
      alh_q       <= 8'h00;
      alm_q       <= 8'h00;
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      ldh_q       <= ldh_d;
      ldm_q       <= ldm_d;
`ifdef CLOCK_SET_ALARM_EN
      alh_q       <= alh_d;
      alm_q       <= alm_d;
      alarm_q     <= alarm_d;
`endif
    end
  end

  assign {ld_h1, ld_h0} = ldh_q;
  assign {ld_m1, ld_m0} = ldm_q;
`ifdef CLOCK_SET_ALARM_EN
  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: two instances (12 h and 24 h) against an integer time-keeping model.
module tb_clock_set_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  int   cur_h = 0, cur_m = 0;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  assign cur_h1 = 4'(cur_h / 10);
  assign cur_h0 = 4'(cur_h % 10);
  assign cur_m1 = 4'(cur_m / 10);
  assign cur_m0 = 4'(cur_m % 10);

  logic       cnt_en0, ld0, cnt_en1, ld1;
  logic [1:0] sel0, sel1;
  logic [3:0] lh1_0, lh0_0, lm1_0, lm0_0, lh1_1, lh0_1, lm1_1, lm0_1;
  logic [19:0] obs [2];
  assign obs[0] = {cnt_en0, ld0, sel0, lh1_0, lh0_0, lm1_0, lm0_0};
  assign obs[1] = {cnt_en1, ld1, sel1, lh1_1, lh0_1, lm1_1, lm0_1};

  always #5 clk = ~clk;

  clock_set_ctrl #(.TICK_DIV(TD), .HOUR_MAX(11)) dut12 (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cnt_en(cnt_en0), .ld(ld0), .ld_h1(lh1_0), .ld_h0(lh0_0), .ld_m1(lm1_0), .ld_m0(lm0_0),
    .sel(sel0));

  clock_set_ctrl #(.TICK_DIV(TD), .HOUR_MAX(23)) dut24 (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cnt_en(cnt_en1), .ld(ld1), .ld_h1(lh1_1), .ld_h0(lh0_1), .ld_m1(lm1_1), .ld_m0(lm0_1),
    .sel(sel1));

  int checks = 0, failures = 0;

  // Reference model: mode 0 run, 1 edit hours, 2 edit minutes, 3 commit; time kept as integers.
  int mode_m [2], hh [2], mm [2], tick [2];
  int hmax [2] = '{11, 23};
  bit pm, pi;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode_m[k] = 0; hh[k] = 0; mm[k] = 0; tick[k] = 0;
    end
    pm = 0; pi = 0;
  endtask

  task automatic model_step();
    bit mp, ip;
    mp = btn_mode && !pm;
    ip = btn_inc && !pi;
    for (int k = 0; k < 2; k++) begin
      case (mode_m[k])
        0: if (mp) begin mode_m[k] = 1; hh[k] = cur_h; mm[k] = cur_m; end
           else tick[k] = (tick[k] + 1) % TD;
        1: if (mp) mode_m[k] = 2; else if (ip) hh[k] = (hh[k] >= hmax[k]) ? 0 : hh[k] + 1;
        2: if (mp) mode_m[k] = 3; else if (ip) mm[k] = (mm[k] >= 59) ? 0 : mm[k] + 1;
        default: begin mode_m[k] = 0; tick[k] = 0; end
      endcase
    end
    pm = btn_mode;
    pi = btn_inc;
  endtask

  function automatic logic [19:0] exp_vec(input int k);
    bit   mp, ce, l;
    logic [1:0] s;
    mp = btn_mode && !pm;
    ce = (mode_m[k] == 0) && !mp && (tick[k] == TD - 1);
    l  = (mode_m[k] == 3);
    s  = (mode_m[k] == 1) ? 2'd1 : (mode_m[k] == 2) ? 2'd2 : 2'd0;
    exp_vec = {ce, l, s, to_bcd(hh[k]), to_bcd(mm[k])};
  endfunction

  task automatic drive_cycle(input bit m, input bit i);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 20'h0) begin
        failures++;
        $display("FAIL reset_state dut=%0d got=%h exp=%h", k, obs[k], 20'h0);
      end
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int c = 0; c < 12; c++) begin
        drive_cycle(0, 0);
        pulses += int'(cnt_en0);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs[k] !== exp_vec(k)) begin
            failures++;
            $display("FAIL run_prescale dut=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_vec(k));
          end
        end
      end
      checks++;
      if (pulses !== 3) begin
        failures++;
        $display("FAIL run_pulse_count got=%0d exp=3", pulses);
      end
    end
  endtask

  // Runs a button script, checks every cycle, returns load counts/values seen.
  task automatic run_script(input string name, input bit [1:0] seq [$],
                            output int lds, output int ens, output logic [15:0] v0, output logic [15:0] v1);
    lds = 0; ens = 0; v0 = 'x; v1 = 'x;
    foreach (seq[n]) begin
      drive_cycle(seq[n][1], seq[n][0]);
      if (ld0) begin lds++; v0 = obs[0][15:0]; v1 = obs[1][15:0]; end
      ens += int'(cnt_en0) + int'(cnt_en1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++;
          $display("FAIL %s dut=%0d step=%0d got=%h exp=%h", name, k, n, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_set_wrap();
    int lds, ens; logic [15:0] v0, v1;
    bit [1:0] seq [$] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    cur_h = 11; cur_m = 58;
    run_script("set_wrap", seq, lds, ens, v0, v1);
    checks++;
    if (lds !== 1 || v0 !== 16'h0000 || v1 !== 16'h1200) begin
      failures++;
      $display("FAIL set_wrap_load got=%0d/%h/%h exp=1/0000/1200", lds, v0, v1);
    end
    checks++;
    if (ens !== 0) begin
      failures++;
      $display("FAIL set_wrap_no_cnt_en got=%0d exp=0", ens);
    end
  endtask

  task automatic test_bcd_carry();
    int lds, ens; logic [15:0] v0, v1;
    bit [1:0] seq [$] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    cur_h = 9; cur_m = 9;
    run_script("bcd_carry", seq, lds, ens, v0, v1);
    checks++;
    if (lds !== 1 || v0 !== 16'h1010 || v1 !== 16'h1010) begin
      failures++;
      $display("FAIL bcd_carry_load got=%0d/%h/%h exp=1/1010/1010", lds, v0, v1);
    end
  endtask

  task automatic test_back_to_back();
    int lds, ens; logic [15:0] v0, v1;
    bit [1:0] seq [$];
    cur_h = 5; cur_m = 30;
    seq = '{2'b10, 2'b00};
    for (int c = 0; c < 20; c++) seq.push_back(2'b01);
    seq.push_back(2'b00);
    seq.push_back(2'b11);
    seq.push_back(2'b00);
    seq.push_back(2'b10);
    seq.push_back(2'b00);
    seq.push_back(2'b00);
    run_script("mode_inc_same", seq, lds, ens, v0, v1);
    checks++;
    if (lds !== 1 || v0 !== 16'h0630 || v1 !== 16'h0630) begin
      failures++;
      $display("FAIL hold_and_collide_load got=%0d/%h/%h exp=1/0630/0630", lds, v0, v1);
    end
  endtask

  task automatic test_reset_mid_set();
    int lds, ens; logic [15:0] v0, v1;
    bit [1:0] seq [$] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    cur_h = 3; cur_m = 14;
    run_script("enter_set_m", seq, lds, ens, v0, v1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 20'h0) begin
        failures++;
        $display("FAIL reset_mid_set dut=%0d got=%h exp=%h", k, obs[k], 20'h0);
      end
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    btn_inc = 1'b0;
    rst_n = 1'b1;
    seq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_script("after_reset", seq, lds, ens, v0, v1);
    checks++;
    if (lds !== 0 || ens !== 2) begin
      failures++;
      $display("FAIL after_reset_counts got=ld%0d/en%0d exp=ld0/en2", lds, ens);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) begin
        cur_h = int'($urandom_range(23));
        cur_m = int'($urandom_range(59));
      end
      drive_cycle(($urandom % 6) == 0, ($urandom % 3) == 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++;
          $display("FAIL random dut=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_wrap();
    test_bcd_carry();
    test_back_to_back();
    test_reset_mid_set();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
